spi_byte_serializer: RTL and testbench

SPI_BYTE_SERIALIZER -- requirements
Module: spi_byte_serializer

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_shift_reg.sv | 53 +++++
 rtl/spi_byte_serializer.sv | 136 +++++++++++++
 tb/tb_spi_byte_serializer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte serializer.
// The bit order is selected at build time by SERIALIZER_LSB_FIRST_EN (see spi_shift_reg).
package spi_pkg;

    // Default word width in bits.
    localparam int SPI_DATA_WIDTH = 8;

    // Serializer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load, one-bit-per-step shift register with serial output.
// Macro SERIALIZER_LSB_FIRST_EN: defined -> bit 0 leaves first (shift right);
// undefined -> bit DATA_WIDTH-1 leaves first (shift left).
module spi_shift_reg
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  sout_o
);

    logic [DATA_WIDTH-1:0] sr_q;
    logic [DATA_WIDTH-1:0] sr_d;

    // Next contents: clear wins over load, load wins over shift.
    always_comb begin
        sr_d = sr_q;
        if (clear_i) begin
            sr_d = '0;
        end else if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
`ifdef SERIALIZER_LSB_FIRST_EN
            sr_d = sr_q >> 1;
`else
            sr_d = sr_q << 1;
`endif
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    // The bit currently on the wire is the one at the outgoing end.
`ifdef SERIALIZER_LSB_FIRST_EN
    assign sout_o = sr_q[0];
`else
    assign sout_o = sr_q[DATA_WIDTH-1];
`endif

endmodule

// File: rtl/spi_byte_serializer.sv
// SPI master-side word serializer: streams memData words onto mosi under cs_n,
// driven by one-clk strobes marking the serial-clock edges.
// Bit order follows macro SERIALIZER_LSB_FIRST_EN (handled in spi_shift_reg);
// all timing is identical in both builds.
module spi_byte_serializer
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclkPosEdge,
    input  logic                  sclkNegEdge,
    input  logic                  txEn,
    input  logic [DATA_WIDTH-1:0] memData,
    output logic                  mosi,
    output logic                  cs_n,
    output logic                  wordDone,
    output logic [CNT_WIDTH-1:0]  wordCount
);

    localparam int             BCW      = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH);

    spi_state_e           state_q, state_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic                 word_done_q, word_done_d;
    logic                 cs_n_q, cs_n_d;

    logic sr_load;
    logic sr_shift;
    logic sr_clear;
    logic sr_out;
    logic neg_only;

    // A coincident pos/neg strobe is treated as a posedge alone.
    assign neg_only = sclkNegEdge & ~sclkPosEdge;

    // Next-state, counters and shift-register controls.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        word_done_d = 1'b0;
        cs_n_d      = cs_n_q;
        sr_load     = 1'b0;
        sr_shift    = 1'b0;
        sr_clear    = 1'b0;

        case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                if (neg_only && txEn) begin
                    state_d = LOAD;
                    cs_n_d  = 1'b0;
                end
            end

            LOAD: begin
                // Word is captured here and only here; first bit appears next cycle.
                sr_load   = 1'b1;
                bit_cnt_d = '0;
                cs_n_d    = 1'b0;
                state_d   = SHIFT;
            end

            SHIFT: begin
                if (sclkPosEdge) begin
                    // Slave samples mosi on this edge; mosi itself holds.
                    if (bit_cnt_q != BIT_LAST) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclkNegEdge) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        // Word boundary: the only point where txEn is consulted.
                        word_done_d = 1'b1;
                        word_cnt_d  = word_cnt_q + 1'b1;
                        sr_clear    = 1'b1;
                        if (txEn) begin
                            state_d = LOAD;
                            cs_n_d  = 1'b0;
                        end else begin
                            state_d = IDLE;
                            cs_n_d  = 1'b1;
                        end
                    end else begin
                        sr_shift = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            word_done_q <= 1'b0;
            cs_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            word_done_q <= word_done_d;
            cs_n_q      <= cs_n_d;
        end
    end

    // Data path; cleared at each word end so mosi idles at 0 outside a word.
    spi_shift_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shift_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (sr_load),
        .shift_i(sr_shift),
        .clear_i(sr_clear),
        .data_i (memData),
        .sout_o (sr_out)
    );

    assign mosi      = sr_out;
    assign cs_n      = cs_n_q;
    assign wordDone  = word_done_q;
    assign wordCount = word_cnt_q;

endmodule

// File: tb/tb_spi_byte_serializer.sv
// Scoreboard bench for spi_byte_serializer: the stimulus queues the words each
// burst must deliver; a monitor rebuilds words from mosi at sclk posedges and
// checks them, the word count and cs_n whenever wordDone pulses.
`timescale 1ns/1ps
module tb_spi_byte_serializer;

    localparam int DW = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sclkPosEdge = 1'b0;
    logic          sclkNegEdge = 1'b0;
    logic          txEn = 1'b0;
    logic [DW-1:0] memData;
    logic          mosi;
    logic          cs_n;
    logic          wordDone;
    logic [CW-1:0] wordCount;

    spi_byte_serializer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclkPosEdge(sclkPosEdge),
        .sclkNegEdge(sclkNegEdge),
        .txEn       (txEn),
        .memData    (memData),
        .mosi       (mosi),
        .cs_n       (cs_n),
        .wordDone   (wordDone),
        .wordCount  (wordCount)
    );

    always #5 clk = ~clk;

    int            vectors = 0;
    int            errors  = 0;
    logic [DW-1:0] mem [256];
    int            pc      = 0;   // memory address of the word the DUT loads next
    int            exp_idx = 0;   // memory address of the next word to queue
    logic [DW-1:0] exp_q [$];
    bit            bits [$];
    int            exp_cnt = 0;
    bit            prev_pos = 1'b0;
    logic          prev_mosi = 1'b0;

    assign memData = mem[pc % 256];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Serial-clock strobe generator: alternating neg/pos strobes 2..4 clks apart,
    // occasionally with a spurious neg strobe riding on a pos strobe.
    initial begin
        int  gap = 2;
        bit  next_pos = 1'b0;
        forever begin
            @(posedge clk); #1;
            sclkPosEdge = 1'b0;
            sclkNegEdge = 1'b0;
            gap--;
            if (gap == 0) begin
                if (next_pos) begin
                    sclkPosEdge = 1'b1;
                    if ($urandom_range(0, 7) == 0) sclkNegEdge = 1'b1;
                end else begin
                    sclkNegEdge = 1'b1;
                end
                next_pos = ~next_pos;
                gap = $urandom_range(2, 4);
            end
        end
    end

    // Monitor: slave-side sampling and scoreboard compare at each wordDone.
    always @(negedge clk) begin
        logic [DW-1:0] got_w;
        logic [DW-1:0] exp_w;
        if (rst) begin
            bits.delete();
            exp_cnt  = 0;
            prev_pos = 1'b0;
        end else begin
            if (prev_pos) check("mosi_stable_after_posedge", 32'(mosi), 32'(prev_mosi));
            if (sclkPosEdge && !cs_n) bits.push_back(mosi);
            if (wordDone) begin
                check("bits_per_word", bits.size(), DW);
                got_w = '0;
                for (int i = 0; i < DW && i < bits.size(); i++) begin
`ifdef SERIALIZER_LSB_FIRST_EN
                    got_w[i] = bits[i];
`else
                    got_w[DW-1-i] = bits[i];
`endif
                end
                bits.delete();
                if (exp_q.size() == 0) begin
                    check("unexpected_wordDone", 32'(wordDone), 32'd0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("word_data", 32'(got_w), 32'(exp_w));
                    // More words queued means the burst continues with cs_n held low.
                    check("cs_n_at_boundary", 32'(cs_n), (exp_q.size() == 0) ? 32'd1 : 32'd0);
                end
                pc++;
                exp_cnt++;
                check("word_count", 32'(wordCount), 32'(exp_cnt % (1 << CW)));
            end
            prev_pos  = sclkPosEdge;
            prev_mosi = mosi;
        end
    end

    task automatic drv_slot();
        @(posedge clk); #1;
    endtask

    task automatic wait_cs_low();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!cs_n) begin ok = 1'b1; break; end
        end
        if (!ok) check("timeout_cs_low", 32'd1, 32'd0);
    endtask

    task automatic wait_pos(input int n);
        int seen = 0;
        for (int i = 0; i < 400 && seen < n; i++) begin
            @(negedge clk);
            if (sclkPosEdge) seen++;
        end
        if (seen < n) check("timeout_posedge", seen, n);
    endtask

    task automatic wait_word_done();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (wordDone) begin ok = 1'b1; break; end
        end
        if (!ok) check("timeout_wordDone", 32'd1, 32'd0);
    endtask

    // Stream n words; for a single word, drop txEn after drop_k sampled bits.
    task automatic run_burst(input int n, input int drop_k);
        bit ok = 1'b0;
        for (int k = 0; k < n; k++) exp_q.push_back(mem[(exp_idx + k) % 256]);
        exp_idx += n;
        drv_slot();
        txEn = 1'b1;
        if (n == 1) begin
            wait_cs_low();
            wait_pos(drop_k);
        end else begin
            repeat (n - 1) wait_word_done();
        end
        drv_slot();
        txEn = 1'b0;
        for (int i = 0; i < 500 * n; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            check("timeout_burst", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
        check("idle_cs_n", 32'(cs_n), 32'd1);
        check("idle_mosi", 32'(mosi), 32'd0);
    endtask

    // Reset in the middle of a word: abandoned, no pulse, count cleared.
    task automatic reset_mid_word();
        drv_slot();
        txEn = 1'b1;
        wait_cs_low();
        wait_pos(5);
        drv_slot();
        rst  = 1'b1;
        txEn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_cs_n", 32'(cs_n), 32'd1);
        check("rst_mid_mosi", 32'(mosi), 32'd0);
        check("rst_mid_wordDone", 32'(wordDone), 32'd0);
        check("rst_mid_wordCount", 32'(wordCount), 32'd0);
        drv_slot();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_wordDone", 32'(wordDone), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        mem[0] = 8'hA5;
        mem[1] = 8'h01;
        mem[2] = 8'h80;
        mem[3] = 8'hFF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cs_n", 32'(cs_n), 32'd1);
        check("reset_mosi", 32'(mosi), 32'd0);
        check("reset_wordDone", 32'(wordDone), 32'd0);
        check("reset_wordCount", 32'(wordCount), 32'd0);
        drv_slot();
        rst = 1'b0;

        run_burst(1, 3);     // 8'hA5, txEn dropped after the third bit
        run_burst(3, 0);     // 01, 80, FF back to back
        reset_mid_word();    // abandons mem[4]; it is re-sent below
        for (int b = 0; b < 10; b++) begin
            run_burst($urandom_range(1, 4), $urandom_range(0, DW - 1));
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
